ms_phase_sequencer: RTL and testbench



---
 rtl/ms_phase_sequencer.sv | 144 ++++++++++++++
 tb/tb_ms_phase_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_phase_sequencer.sv
// ms_phase_sequencer: turns a debounced STEP button or a RUN level into
// non-overlapping master/slave latch enables with programmable dead time.
// It also drives each latch's set/reset pins during its open phase.
// Optional feature macro: MS_STEPCNT_EN builds the completed-cycle counter on
// STEPCNT. When it is undefined, STEPCNT is tied to zero.
module ms_phase_sequencer #(
   parameter int PHASE_CYCLES = 4,
   parameter int DEAD_CYCLES  = 2
) (
   input  logic       CLKIN,
   input  logic       RESET,
   input  logic       STEP,
   input  logic       RUN,
   input  logic       D,
   input  logic       QM,
   output logic       CM,
   output logic       SM,
   output logic       RM,
   output logic       CS,
   output logic       SS,
   output logic       RS,
   output logic       BUSY,
   output logic [7:0] STEPCNT
);
   localparam logic [7:0] PHASE_LD = 8'(PHASE_CYCLES - 1);
   localparam logic [7:0] DEAD_LD  = 8'(DEAD_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, M_OPEN, GAP1, S_OPEN, GAP2} state_t;

   state_t     state, state_n;
   logic [2:0] step_sync;
   logic [1:0] run_sync;
   logic [7:0] cnt, cnt_n;
   logic       pend, pend_n;
   logic       dl, dl_n;
   logic       ql, ql_n;
   logic       step_edge, run_req, cnt_done;

   assign step_edge = step_sync[1] & ~step_sync[2];
   assign run_req   = run_sync[1];
   assign cnt_done  = (cnt == 8'd0);

   // Bring STEP and RUN into the CLKIN domain. STEP gets an extra flop so a rising edge can be detected.
   always_ff @(posedge CLKIN) begin
      if (RESET) begin
         step_sync <= '0;
         run_sync  <= '0;
      end else begin
         step_sync <= {step_sync[1:0], STEP};
         run_sync  <= {run_sync[0], RUN};
      end
   end

   // Next-state logic. The phase/dead counter reloads on every state entry.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pend_n  = pend | step_edge;
      dl_n    = dl;
      ql_n    = ql;
      if (!cnt_done) cnt_n = cnt - 8'd1;
      unique case (state)
         IDLE: if (pend || run_req) begin
            state_n = M_OPEN; cnt_n = PHASE_LD; dl_n = D; pend_n = 1'b0;
         end
         M_OPEN: if (cnt_done) begin
            state_n = GAP1; cnt_n = DEAD_LD;
         end
         // QM is sampled on the last dead cycle, so the master has fully settled.
         GAP1: if (cnt_done) begin
            state_n = S_OPEN; cnt_n = PHASE_LD; ql_n = QM;
         end
         S_OPEN: if (cnt_done) begin
            state_n = GAP2; cnt_n = DEAD_LD;
         end
         // An edge arriving on the exit cycle is consumed here and is never parked in PEND.
         GAP2: if (cnt_done) begin
            if (run_req || pend || step_edge) begin
               state_n = M_OPEN; cnt_n = PHASE_LD; dl_n = D; pend_n = 1'b0;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State register, counter and request/data holding flops.
   always_ff @(posedge CLKIN) begin
      if (RESET) begin
         state <= IDLE;
         cnt   <= '0;
         pend  <= 1'b0;
         dl    <= 1'b0;
         ql    <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         pend  <= pend_n;
         dl    <= dl_n;
         ql    <= ql_n;
      end
   end

   // Registered outputs, decoded from the next state so they align with it.
   // Set/reset pins keep their last value while their latch is closed.
   always_ff @(posedge CLKIN) begin
      if (RESET) begin
         CM   <= 1'b0;
         CS   <= 1'b0;
         SM   <= 1'b0;
         RM   <= 1'b0;
         SS   <= 1'b0;
         RS   <= 1'b0;
         BUSY <= 1'b0;
      end else begin
         CM   <= (state_n == M_OPEN);
         CS   <= (state_n == S_OPEN);
         BUSY <= (state_n != IDLE);
         if (state_n == M_OPEN) begin
            SM <= dl_n;
            RM <= ~dl_n;
         end
         if (state_n == S_OPEN) begin
            SS <= ql_n;
            RS <= ~ql_n;
         end
      end
   end

`ifdef MS_STEPCNT_EN
   logic cycle_done;
   assign cycle_done = (state == GAP2) && cnt_done;

   // Count completed cycles. The counter wraps from 255 back to 0.
   always_ff @(posedge CLKIN) begin
      if (RESET) STEPCNT <= 8'h00;
      else if (cycle_done) STEPCNT <= STEPCNT + 8'd1;
   end
`else
   assign STEPCNT = 8'h00;
`endif

endmodule

// File: tb/tb_ms_phase_sequencer.sv
// Testbench for ms_phase_sequencer. A reference model predicts each master/slave cycle.
// A monitor measures the real cycles and compares them with the predictions.
// A second instance (PHASE=1, DEAD=1) has its 4-cycle pattern checked separately.
module tb_ms_phase_sequencer;
   localparam int P  = 4;
   localparam int DC = 2;
   localparam int L  = 2*P + 2*DC;

   logic clk = 1'b0, rst = 1'b1, step = 1'b0, run = 1'b0, d = 1'b0;
   logic qm = 1'b0, qm1 = 1'b0;
   logic cm, sm, rm, cs, ss, rs, busy;
   logic cm1, sm1, rm1, cs1, ss1, rs1, busy1;
   logic [7:0] stepcnt, stepcnt1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ms_phase_sequencer #(.PHASE_CYCLES(P), .DEAD_CYCLES(DC)) dut (
      .CLKIN(clk), .RESET(rst), .STEP(step), .RUN(run), .D(d), .QM(qm),
      .CM(cm), .SM(sm), .RM(rm), .CS(cs), .SS(ss), .RS(rs), .BUSY(busy),
      .STEPCNT(stepcnt));

   ms_phase_sequencer #(.PHASE_CYCLES(1), .DEAD_CYCLES(1)) dut1 (
      .CLKIN(clk), .RESET(rst), .STEP(step), .RUN(run), .D(d), .QM(qm1),
      .CM(cm1), .SM(sm1), .RM(rm1), .CS(cs1), .SS(ss1), .RS(rs1), .BUSY(busy1),
      .STEPCNT(stepcnt1));

   // Master latch models: each master is transparent while its enable is high.
   always @(negedge clk) begin
      if (cm)  qm  <= sm  ? 1'b1 : (rm  ? 1'b0 : qm);
      if (cm1) qm1 <= sm1 ? 1'b1 : (rm1 ? 1'b0 : qm1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed { logic d; logic [7:0] cnt; } exp_t;
   exp_t expq[$];
   exp_t rec;
   logic [2:0] sh = '0;
   logic [1:0] rh = '0;
   logic pend_m = 1'b0, edge_m, run_m, rst_seen = 1'b1;
   int   active_m = 0, t_end = 0, k_m = 0;
   logic [7:0] cnt_m = '0;

   task automatic model_start();
      active_m = 1;
      t_end    = k_m + L;
      pend_m   = 1'b0;
      cnt_m    = cnt_m + 8'd1;
      rec.d    = d;
`ifdef MS_STEPCNT_EN
      rec.cnt  = cnt_m;
`else
      rec.cnt  = 8'h00;
`endif
      expq.push_back(rec);
   endtask

   // The model has three rules. A cycle lasts L edges. A request is a pending step,
   // a RUN level or a step edge at cycle end. At most one step stays queued.
   initial forever begin
      @(posedge clk);
      rst_seen = rst;
      if (rst) begin
         sh = '0; rh = '0; pend_m = 1'b0; active_m = 0; cnt_m = '0;
         expq.delete();
      end else begin
         edge_m = sh[1] & ~sh[2];
         run_m  = rh[1];
         if (active_m != 0 && k_m == t_end) begin
            active_m = 0;
            if (run_m || pend_m || edge_m) model_start();
         end else if (active_m == 0) begin
            if (pend_m || run_m) model_start();
            else pend_m = pend_m | edge_m;
         end else begin
            pend_m = pend_m | edge_m;
         end
         sh = {sh[1:0], step};
         rh = {rh[0], run};
      end
      k_m++;
   end

   // ---------------- monitor ----------------
   int   mst = 0, mc = 0;
   exp_t cur;

   task automatic mon_open();
      mst = 1; mc = 1;
      if (expq.size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_cycle: got CM rise required none at %0t", $time);
         cur.d = sm; cur.cnt = stepcnt;
      end else begin
         cur = expq.pop_front();
         check("sm_open", sm, cur.d);
         check("rm_open", rm, !cur.d);
         check("busy_open", busy, 1);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (rst_seen) begin
         mst = 0; mc = 0;
      end else begin
         check("no_overlap", cm & cs, 0);
         case (mst)
            0: if (cm) mon_open(); else check("idle_busy", busy, 0);
            1: if (cm) mc++;
               else begin check("cm_width", mc, P); mst = 2; mc = 1; end
            2: if (cs) begin
                  check("gap1", mc, DC);
                  check("ss_open", ss, cur.d);
                  check("rs_open", rs, !cur.d);
                  mst = 3; mc = 1;
               end else begin
                  check("gap1_cm", cm, 0);
                  mc++;
               end
            3: if (cs) mc++;
               else begin
                  check("cs_width", mc, P);
                  check("sm_hold", sm, cur.d);
                  mst = 4; mc = 1;
               end
            default: if (cm || !busy) begin
                  check("gap2", mc, DC);
                  check("stepcnt", stepcnt, cur.cnt);
                  if (cm) mon_open(); else mst = 0;
               end else mc++;
         endcase
         if (mc > 1000) begin check("stall", mc, 0); mst = 0; mc = 0; end
      end
   end

   // ---------------- short-period instance pattern checker ----------------
   logic [4:0] cmh = '0, csh = '0, bh = '0;
   int p1n = 0;
   initial forever begin
      @(negedge clk);
      if (rst_seen) begin
         cmh = '0; csh = '0; bh = '0;
      end else begin
         cmh = {cmh[3:0], cm1}; csh = {csh[3:0], cs1}; bh = {bh[3:0], busy1};
         check("p1_overlap", cm1 & cs1, 0);
         if (cm1) check("p1_smrm", rm1, !sm1);
         if (cs1) check("p1_ssrs", rs1, !ss1);
         if (&bh) begin
            check("p1_period", cmh[0], cmh[4]);
            check("p1_cs_after_gap", csh[0], cmh[2]);
            p1n++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle();
      int n = 0, q = 0;
      repeat (4) @(negedge clk);
      while (q < 3 && n < 3000) begin
         @(negedge clk);
         n++;
         if (active_m == 0 && !pend_m && mst == 0 && expq.size() == 0 && !busy) q++;
         else q = 0;
      end
      check("idle_timeout", (q >= 3), 1);
   endtask

   task automatic wait_cm();
      int n = 0;
      while (!cm && n < 200) begin @(negedge clk); n++; end
      check("wait_cm", cm, 1);
   endtask

   task automatic do_step(input logic dv);
      @(negedge clk);
      d = dv; step = 1'b1;
      repeat (2) @(negedge clk);
      step = 1'b0;
      wait_idle();
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cm", cm, 0);   check("rst_cs", cs, 0);
      check("rst_sm", sm, 0);   check("rst_rm", rm, 0);
      check("rst_ss", ss, 0);   check("rst_rs", rs, 0);
      check("rst_busy", busy, 0); check("rst_stepcnt", stepcnt, 0);
      rst = 1'b0;

      // single steps with both data values
      do_step(1'b1);
      do_step(1'b0);

      // queued steps: two edges in M_OPEN, a third in S_OPEN -> two cycles
      @(negedge clk); d = 1'b1; step = 1'b1;
      @(negedge clk); step = 1'b0;
      wait_cm();
      step = 1'b1; @(negedge clk); step = 1'b0; @(negedge clk);
      step = 1'b1; @(negedge clk); step = 1'b0;
      begin
         int n = 0;
         while (!cs && n < 200) begin @(negedge clk); n++; end
         check("wait_cs", cs, 1);
      end
      step = 1'b1; @(negedge clk); step = 1'b0;
      wait_idle();

      // free run for 100 cycles with changing data
      run = 1'b1;
      repeat (100) begin @(negedge clk); d = 1'($urandom); end
      run = 1'b0;
      wait_idle();

      // randomized STEP/RUN/D
      repeat (800) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0)  step = ~step;
         if ($urandom_range(0, 59) == 0) run  = ~run;
         d = 1'($urandom);
      end
      run = 1'b0; step = 1'b0;
      wait_idle();

      // reset in the middle of M_OPEN discards everything
      @(negedge clk); d = 1'b1; step = 1'b1;
      @(negedge clk); step = 1'b0;
      wait_cm();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_cm", cm, 0); check("midrst_cs", cs, 0);
      check("midrst_busy", busy, 0); check("midrst_stepcnt", stepcnt, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("midrst_stays_idle", busy, 0);

      // 256 steps wrap the counter back to zero
      repeat (256) do_step(1'($urandom));
      check("wrap_stepcnt", stepcnt, 0);
      check("p1_exercised", (p1n > 0), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
